multi_bridge: RTL and testbench
===============================

MULTI_BRIDGE -- requirements
Module: multi_bridge
Interface
REQ-001 SHALL have parameter NCH: default 2; number of client channels (1..8).
REQ-002 SHALL have parameter DW: default 64; data width; AXI address stride = DW/8 bytes.
REQ-003 SHALL have parameter CAW: default 8; client address width.
REQ-004 SHALL have parameter BASE: default 17'h10000; AXI base address for a 17-bit AXI address bus.
REQ-005 SHALL have port clk: input, 1 bit; the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n: input, 1 bit; asynchronous, active-low reset.
REQ-007 SHALL have port C_in_valid: input, NCH bits; per-channel request valid; held by client until C_in_ready.
REQ-008 SHALL have port C_r_wb: input, NCH bits; per-channel direction; 1 = read, 0 = write.
REQ-009 SHALL have port C_addr: input, NCH*CAW bits; per-channel word address; channel i at slice i.
REQ-010 SHALL have port C_data_w: input, NCH*DW bits; per-channel write data.
REQ-011 SHALL have port C_in_ready: output, NCH bits; one-cycle grant/accept pulse.
REQ-012 SHALL have port C_out_valid: output, NCH bits; one-cycle completion pulse to the owning channel.
REQ-013 SHALL have port C_data_r: output, DW bits; read data, shared by all channels.
REQ-014 SHALL have port C_err: output, NCH bits; response-error flag, qualified by C_out_valid.
REQ-015 SHALL have port AR_VALID: output, 1 bit; read address valid.
REQ-016 SHALL have port AR_ADDR: output, 17 bits; read byte address.
REQ-017 SHALL have port AR_READY: input, 1 bit; read address ready.
REQ-018 SHALL have port R_VALID: input, 1 bit; read data valid.
REQ-019 SHALL have port R_DATA: input, DW bits; read data.
REQ-020 SHALL have port R_RESP: input, 2 bits; read response code.
REQ-021 SHALL have port R_READY: output, 1 bit; read data ready.
REQ-022 SHALL have port AW_VALID: output, 1 bit; write address valid.
REQ-023 SHALL have port AW_ADDR: output, 17 bits; write byte address.
REQ-024 SHALL have port AW_READY: input, 1 bit; write address ready.
REQ-025 SHALL have port W_VALID: output, 1 bit; write data valid.
REQ-026 SHALL have port W_DATA: output, DW bits; write data.
REQ-027 SHALL have port W_READY: input, 1 bit; write data ready.
REQ-028 SHALL have port B_VALID: input, 1 bit; write response valid.
REQ-029 SHALL have port B_RESP: input, 2 bits; write response code.
REQ-030 SHALL have port B_READY: output, 1 bit; write response ready.
Function
REQ-031 SHALL implement FSM IDLE, AR, R, WR, B with these transitions: IDLE->AR on a read grant, IDLE->WR on a write grant; AR->R on AR handshake; R->IDLE on R handshake; WR->B once both AW and W handshakes are done (either order, or the same cycle); B->IDLE on B handshake.
REQ-032 SHALL arbitrate in IDLE only: round-robin over C_in_valid starting at ptr; pulse C_in_ready[g] for one cycle; capture r_wb/addr/data of channel g; set ptr <= (g+1) mod NCH; requests arriving while busy wait.
REQ-033 SHALL drive AR_ADDR/AW_ADDR = BASE + C_addr*(DW/8), computed in 17 bits, wrapping modulo 2^17, held stable while the corresponding VALID is high.
REQ-034 SHALL assert AR_VALID (read) or AW_VALID+W_VALID (write) in the cycle after the grant; each VALID clears in the cycle after its own handshake and never drops before it; W_DATA stays stable until the W handshake.
REQ-035 SHALL drive R_READY high only in state R and B_READY high only in state B; R_VALID/B_VALID in any other state are not acknowledged.
REQ-036 SHALL, in the cycle after the R or B handshake, drive C_out_valid[owner]=1 for exactly one cycle; C_data_r = captured R_DATA for reads, 0 for writes and whenever C_out_valid is all-zero.
REQ-037 SHALL allow only one transaction outstanding; the next grant can occur in the same cycle C_out_valid pulses (FSM back in IDLE).
Reset
REQ-038 SHALL, on rst_n low at any time including mid-transaction, immediately force all outputs to 0, state IDLE, ptr 0; the in-flight transaction is dropped.
Configuration
REQ-039 SHALL, when MULTI_BRIDGE_RESP_CHECK_EN is defined, set C_err[owner] = (RESP != 2'b00) together with C_out_valid and force C_data_r to 0 on a read error; when undefined, C_err is tied to 0 and R_RESP/B_RESP are ignored (ports retained).
Structure
REQ-040 SHALL put the state enum, RESP code constants and the default BASE in package multi_bridge_pkg; the round-robin arbiter SHALL be sub-module multi_bridge_rr_arb (NCH-parameterised, request/grant/ptr).
Verification
REQ-041 SHALL cover: ch0 read, C_addr 8'h05, AR_READY after 3 cycles, R_DATA 64'hDEADBEEF01234567 -> AR_ADDR 17'h10028 stable until handshake; C_out_valid[0] one cycle with that data.
REQ-042 SHALL cover: ch1 write, C_addr 8'hFF, data 64'h1, W_READY two cycles before AW_READY -> AW_ADDR 17'h107F8; B_READY only after both handshakes; C_out_valid[1]=1 with C_data_r=0.
REQ-043 SHALL cover: ch0 and ch1 issuing back-to-back reads continuously -> grants alternate 0,1,0,1; no channel is starved.
REQ-044 SHALL cover: rst_n low during WR with AW_VALID=1 -> all outputs 0 in the same cycle; after release, a ch1 request is granted first (ptr=0 with only ch1 requesting).
REQ-045 SHALL cover: ch0 write with B_RESP=2'b10 -> C_err[0]=1 with C_out_valid[0] when the macro is defined; C_err=0 when it is undefined.

Source files
------------

// File: rtl/multi_bridge_pkg.sv
// Shared types and constants for the multi-client AXI-lite bridge.
package multi_bridge_pkg;

  localparam int AXI_AW = 17;
  localparam logic [AXI_AW-1:0] DEFAULT_BASE = 17'h10000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_WR,
    ST_B
  } state_e;

endpackage

// File: rtl/multi_bridge_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module multi_bridge_rr_arb #(
  parameter int NCH = 2,
  parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req_i,
  input  logic [PW-1:0]  ptr_i,
  output logic           gnt_valid_o,
  output logic [PW-1:0]  gnt_idx_o,
  output logic [NCH-1:0] gnt_o
);

  int idx;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    gnt_o       = '0;
    idx         = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(ptr_i) + k) % NCH;
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = PW'(idx);
        gnt_o[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_bridge.sv
// Multi-client to AXI-lite bridge, one transaction outstanding.
// Define MULTI_BRIDGE_RESP_CHECK_EN to report non-OKAY responses on C_err.
module multi_bridge
  import multi_bridge_pkg::*;
#(
  parameter int                NCH  = 2,
  parameter int                DW   = 64,
  parameter int                CAW  = 8,
  parameter logic [AXI_AW-1:0] BASE = DEFAULT_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    C_in_valid,
  input  logic [NCH-1:0]    C_r_wb,
  input  logic [NCH*CAW-1:0] C_addr,
  input  logic [NCH*DW-1:0] C_data_w,
  output logic [NCH-1:0]    C_in_ready,
  output logic [NCH-1:0]    C_out_valid,
  output logic [DW-1:0]     C_data_r,
  output logic [NCH-1:0]    C_err,
  output logic              AR_VALID,
  output logic [AXI_AW-1:0] AR_ADDR,
  input  logic              AR_READY,
  input  logic              R_VALID,
  input  logic [DW-1:0]     R_DATA,
  input  logic [1:0]        R_RESP,
  output logic              R_READY,
  output logic              AW_VALID,
  output logic [AXI_AW-1:0] AW_ADDR,
  input  logic              AW_READY,
  output logic              W_VALID,
  output logic [DW-1:0]     W_DATA,
  input  logic              W_READY,
  input  logic              B_VALID,
  input  logic [1:0]        B_RESP,
  output logic              B_READY
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AXI_AW-1:0] STRIDE = AXI_AW'(DW / 8);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d, owner_q, gnt_idx;
  logic [NCH-1:0]    gnt, out_valid_q, err_q;
  logic              gnt_valid, grant;
  logic [AXI_AW-1:0] addr_q, gnt_addr;
  logic [DW-1:0]     wdata_q, data_r_q;
  logic              aw_done_q, w_done_q;
  logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic              r_err, b_err;

  multi_bridge_rr_arb #(.NCH(NCH), .PW(PW)) u_arb (
    .req_i      (C_in_valid),
    .ptr_i      (ptr_q),
    .gnt_valid_o(gnt_valid),
    .gnt_idx_o  (gnt_idx),
    .gnt_o      (gnt)
  );

  assign grant    = (state_q == ST_IDLE) && gnt_valid;
  assign gnt_addr = BASE + AXI_AW'(C_addr[int'(gnt_idx)*CAW +: CAW]) * STRIDE;
  assign ptr_d    = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + PW'(1);

  assign ar_hs = AR_VALID && AR_READY;
  assign r_hs  = R_READY  && R_VALID;
  assign aw_hs = AW_VALID && AW_READY;
  assign w_hs  = W_VALID  && W_READY;
  assign b_hs  = B_READY  && B_VALID;

`ifdef MULTI_BRIDGE_RESP_CHECK_EN
  assign r_err = (R_RESP != RESP_OKAY);
  assign b_err = (B_RESP != RESP_OKAY);
`else
  logic unused_resp;
  assign unused_resp = ^{R_RESP, B_RESP};
  assign r_err = 1'b0;
  assign b_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (grant) state_d = C_r_wb[gnt_idx] ? ST_AR : ST_WR;
      ST_AR:   if (ar_hs) state_d = ST_R;
      ST_R:    if (r_hs)  state_d = ST_IDLE;
      ST_WR:   if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_B;
      ST_B:    if (b_hs)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    AR_VALID    = (state_q == ST_AR);
    R_READY     = (state_q == ST_R);
    AW_VALID    = (state_q == ST_WR) && !aw_done_q;
    W_VALID     = (state_q == ST_WR) && !w_done_q;
    B_READY     = (state_q == ST_B);
    // Grant is combinational from C_in_valid, so gate it while reset is held.
    C_in_ready  = (grant && rst_n) ? gnt : '0;
    AR_ADDR     = addr_q;
    AW_ADDR     = addr_q;
    W_DATA      = wdata_q;
    C_out_valid = out_valid_q;
    C_data_r    = data_r_q;
    C_err       = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      out_valid_q <= '0;
      err_q       <= '0;
      data_r_q    <= '0;
    end else begin
      out_valid_q <= '0;
      err_q       <= '0;
      data_r_q    <= '0;
      if (grant) begin
        ptr_q     <= ptr_d;
        owner_q   <= gnt_idx;
        addr_q    <= gnt_addr;
        wdata_q   <= C_data_w[int'(gnt_idx)*DW +: DW];
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (r_hs) begin
        out_valid_q[owner_q] <= 1'b1;
        err_q[owner_q]       <= r_err;
        data_r_q             <= r_err ? '0 : R_DATA;
      end
      if (b_hs) begin
        out_valid_q[owner_q] <= 1'b1;
        err_q[owner_q]       <= b_err;
      end
    end
  end

endmodule

// File: tb/tb_multi_bridge.sv
// Directed self-checking bench for multi_bridge (NCH=2, DW=64, CAW=8).
module tb_multi_bridge;

  localparam int NCH = 2;
  localparam int DW  = 64;
  localparam int CAW = 8;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    C_in_valid, C_r_wb, C_in_ready, C_out_valid, C_err;
  logic [NCH*CAW-1:0] C_addr;
  logic [NCH*DW-1:0] C_data_w;
  logic [DW-1:0]     C_data_r, R_DATA, W_DATA;
  logic              AR_VALID, AR_READY, R_VALID, R_READY;
  logic              AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic [16:0]       AR_ADDR, AW_ADDR;
  logic [1:0]        R_RESP, B_RESP;

  int n_total = 0;
  int n_bad   = 0;

`ifdef MULTI_BRIDGE_RESP_CHECK_EN
  localparam logic EN = 1'b1;
`else
  localparam logic EN = 1'b0;
`endif

  multi_bridge #(.NCH(NCH), .DW(DW), .CAW(CAW), .BASE(17'h10000)) dut (
    .clk(clk), .rst_n(rst_n),
    .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
    .C_in_ready(C_in_ready), .C_out_valid(C_out_valid), .C_data_r(C_data_r), .C_err(C_err),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"},  C_in_ready,  0);
    check({tag, ".out_valid"}, C_out_valid, 0);
    check({tag, ".data_r"},    C_data_r,    0);
    check({tag, ".err"},       C_err,       0);
    check({tag, ".axi_valid"}, {AR_VALID, AW_VALID, W_VALID, R_READY, B_READY}, 0);
    check({tag, ".ar_addr"},   AR_ADDR,     0);
    check({tag, ".aw_addr"},   AW_ADDR,     0);
    check({tag, ".w_data"},    W_DATA,      0);
  endtask

  initial begin
    rst_n = 1'b0;
    C_in_valid = '0; C_r_wb = '0; C_addr = '0; C_data_w = '0;
    AR_READY = 0; R_VALID = 0; R_DATA = '0; R_RESP = '0;
    AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = '0;

    // Reset: outputs zero even with requests pending.
    C_in_valid = 2'b11;
    #12;
    check_all_zero("reset");
    C_in_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // ch0 read, address 5, AR_READY after 3 cycles.
    C_in_valid = 2'b01; C_r_wb = 2'b01; C_addr = {8'h00, 8'h05};
    #1 check("rd0.grant", C_in_ready, 2'b01);
    tick();
    C_in_valid = '0;
    for (int i = 0; i < 3; i++) begin
      check("rd0.ar_valid_wait", AR_VALID, 1);
      check("rd0.ar_addr_wait", AR_ADDR, 17'h10028);
      tick();
    end
    AR_READY = 1;
    #1 check("rd0.r_ready_early", R_READY, 0);
    tick();
    AR_READY = 0;
    check("rd0.ar_valid_drop", AR_VALID, 0);
    check("rd0.r_ready", R_READY, 1);
    R_VALID = 1; R_DATA = 64'hDEADBEEF01234567;
    tick();
    R_VALID = 0;
    check("rd0.out_valid", C_out_valid, 2'b01);
    check("rd0.data_r", C_data_r, 64'hDEADBEEF01234567);
    check("rd0.err", C_err, 2'b00);
    tick();
    check("rd0.out_valid_pulse", C_out_valid, 2'b00);
    check("rd0.data_r_idle", C_data_r, 0);

    // ch1 write, address FF, W_READY two cycles before AW_READY.
    C_in_valid = 2'b10; C_r_wb = 2'b00; C_addr = {8'hFF, 8'h00};
    C_data_w = {64'h1, 64'h0};
    #1 check("wr1.grant", C_in_ready, 2'b10);
    tick();
    C_in_valid = '0;
    check("wr1.valids", {AW_VALID, W_VALID}, 2'b11);
    check("wr1.aw_addr", AW_ADDR, 17'h107F8);
    check("wr1.w_data", W_DATA, 64'h1);
    W_READY = 1;
    tick();
    W_READY = 0;
    check("wr1.w_drop", {AW_VALID, W_VALID, B_READY}, 3'b100);
    tick();
    check("wr1.aw_hold", AW_VALID, 1);
    check("wr1.aw_addr_hold", AW_ADDR, 17'h107F8);
    check("wr1.b_ready_early", B_READY, 0);
    AW_READY = 1;
    tick();
    AW_READY = 0;
    check("wr1.aw_drop", AW_VALID, 0);
    check("wr1.b_ready", B_READY, 1);
    B_VALID = 1; B_RESP = 2'b00;
    tick();
    B_VALID = 0;
    check("wr1.out_valid", C_out_valid, 2'b10);
    check("wr1.data_r", C_data_r, 0);
    tick();

    // R_VALID while idle must not be acknowledged.
    R_VALID = 1; R_DATA = 64'h55;
    #1 check("idle.r_ready", R_READY, 0);
    tick();
    R_VALID = 0;
    check("idle.no_out_valid", C_out_valid, 2'b00);

    // Both channels reading continuously: grants alternate 0,1,0,1.
    C_in_valid = 2'b11; C_r_wb = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_g;
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      #1 check("rr.grant", C_in_ready, exp_g);
      tick();
      check("rr.ar_valid", AR_VALID, 1);
      AR_READY = 1;
      tick();
      AR_READY = 0;
      R_VALID = 1; R_DATA = 64'(i + 100);
      tick();
      R_VALID = 0;
      check("rr.out_valid", C_out_valid, exp_g);
      check("rr.data_r", C_data_r, 64'(i + 100));
    end
    #1 C_in_valid = '0;
    tick();

    // Reset during WR with AW_VALID high; ptr returns to 0.
    C_in_valid = 2'b01; C_r_wb = 2'b00; C_data_w = {64'h0, 64'hABCD};
    #1 check("rst.grant", C_in_ready, 2'b01);
    tick();
    C_in_valid = '0;
    check("rst.aw_valid", AW_VALID, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    tick();
    rst_n = 1'b1;
    C_in_valid = 2'b10; C_r_wb = 2'b10;
    #1 check("rst.ch1_only", C_in_ready, 2'b10);
    C_in_valid = 2'b11;
    #1 check("rst.ptr_zero", C_in_ready, 2'b01);
    C_in_valid = '0;
    tick();
    check("rst.still_idle", {AR_VALID, AW_VALID, W_VALID}, 3'b000);

    // ch0 write with SLVERR response.
    C_in_valid = 2'b01; C_r_wb = 2'b00; C_addr = {8'h00, 8'h03};
    #1 tick();
    C_in_valid = '0;
    AW_READY = 1; W_READY = 1;
    tick();
    AW_READY = 0; W_READY = 0;
    check("berr.b_ready", {AW_VALID, W_VALID, B_READY}, 3'b001);
    B_VALID = 1; B_RESP = 2'b10;
    tick();
    B_VALID = 0; B_RESP = 2'b00;
    check("berr.out_valid", C_out_valid, 2'b01);
    check("berr.err", C_err, {1'b0, EN});

    // ch1 read with DECERR response.
    C_in_valid = 2'b10; C_r_wb = 2'b10;
    #1 check("rerr.grant", C_in_ready, 2'b10);
    tick();
    C_in_valid = '0;
    AR_READY = 1;
    tick();
    AR_READY = 0;
    R_VALID = 1; R_RESP = 2'b11; R_DATA = 64'hCAFE;
    tick();
    R_VALID = 0; R_RESP = 2'b00;
    check("rerr.out_valid", C_out_valid, 2'b10);
    check("rerr.err", C_err, {EN, 1'b0});
    check("rerr.data_r", C_data_r, EN ? 64'h0 : 64'hCAFE);
    tick();
    check("rerr.err_clear", C_err, 2'b00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
